// File: rtl/cfg_loader.sv
// cfg_loader: serial configuration loader with CRC-8 check and readback.
// A bitstream of CFG_W bits followed by an 8-bit CRC (MSB first) is
// shifted into a shadow register. On a CRC match the shadow is copied to
// the switch-control bus `c` in a single cycle. Readback streams `c`
// LSB first, followed by its CRC-8 MSB first.
module cfg_loader #(
  parameter int          CFG_W    = 248,
  parameter int          CNT_W    = 8,
  parameter logic [7:0]  CRC_POLY = 8'h07
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             rb_req,
  input  logic             in_valid,
  input  logic             in_bit,
  output logic             in_ready,
  output logic             out_valid,
  output logic             out_bit,
  output logic             out_last,
  input  logic             out_ready,
  output logic [CFG_W-1:0] c,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_CRC_RX  = 3'd2,
    ST_COMMIT  = 3'd3,
    ST_ERROR   = 3'd4,
    ST_RB_DATA = 3'd5,
    ST_RB_CRC  = 3'd6
  } state_t;

  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(CFG_W - 1);
  localparam logic [CNT_W-1:0] LAST_CRC  = CNT_W'(7);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);

  // One bit-serial CRC-8 step: no reflection, polynomial with implicit x^8.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc_in, input logic b);
    logic fb;
    fb = crc_in[7] ^ b;
    crc8_step = {crc_in[6:0], 1'b0} ^ (fb ? CRC_POLY : 8'h00);
  endfunction

  state_t             state_q, state_d;
  logic [CFG_W-1:0]   c_q, c_d;
  logic [CFG_W-1:0]   shadow_q, shadow_d;
  logic [CFG_W-1:0]   rb_q, rb_d;
  logic [7:0]         crc_q, crc_d;
  logic [7:0]         rx_crc_q, rx_crc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;

  logic               in_acc_s;
  logic               out_acc_s;
  logic [7:0]         rx_crc_next_s;

  // Outputs are pure decodes of registered state, so reset clears them at once.
  assign in_ready  = (state_q == ST_LOAD) || (state_q == ST_CRC_RX);
  assign out_valid = (state_q == ST_RB_DATA) || (state_q == ST_RB_CRC);
  assign out_bit   = (state_q == ST_RB_DATA) ? rb_q[0] :
                     (state_q == ST_RB_CRC)  ? crc_q[3'd7 - cnt_q[2:0]] : 1'b0;
  assign out_last  = (state_q == ST_RB_CRC) && (cnt_q == LAST_CRC);
  assign busy      = (state_q != ST_IDLE) && (state_q != ST_ERROR);
  assign done      = (state_q == ST_COMMIT);
  assign err       = err_q;
  assign c         = c_q;

  assign in_acc_s      = in_valid & in_ready;
  assign out_acc_s     = out_valid & out_ready;
  assign rx_crc_next_s = {rx_crc_q[6:0], in_bit};

  // State register and datapath flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      c_q      <= '0;
      shadow_q <= '0;
      rb_q     <= '0;
      crc_q    <= 8'h00;
      rx_crc_q <= 8'h00;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      c_q      <= c_d;
      shadow_q <= shadow_d;
      rb_q     <= rb_d;
      crc_q    <= crc_d;
      rx_crc_q <= rx_crc_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  // Next-state and datapath update logic.
  always_comb begin
    state_d  = state_q;
    c_d      = c_q;
    shadow_d = shadow_q;
    rb_d     = rb_q;
    crc_d    = crc_q;
    rx_crc_d = rx_crc_q;
    cnt_d    = cnt_q;
    err_d    = err_q;

    case (state_q)
      ST_IDLE, ST_ERROR: begin
        if (start) begin
          state_d = ST_LOAD;
          cnt_d   = CNT_ZERO;
          crc_d   = 8'h00;
          err_d   = 1'b0;
        end else if (rb_req) begin
          state_d = ST_RB_DATA;
          rb_d    = c_q;
          cnt_d   = CNT_ZERO;
          crc_d   = 8'h00;
        end else begin
          state_d = state_q;
        end
      end

      ST_LOAD: begin
        if (start) begin
          cnt_d = CNT_ZERO;
          crc_d = 8'h00;
        end else if (in_acc_s) begin
          shadow_d = {in_bit, shadow_q[CFG_W-1:1]};
          crc_d    = crc8_step(crc_q, in_bit);
          if (cnt_q == LAST_DATA) begin
            state_d  = ST_CRC_RX;
            cnt_d    = CNT_ZERO;
            rx_crc_d = 8'h00;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end else begin
          state_d = ST_LOAD;
        end
      end

      ST_CRC_RX: begin
        if (start) begin
          state_d = ST_LOAD;
          cnt_d   = CNT_ZERO;
          crc_d   = 8'h00;
        end else if (in_acc_s) begin
          rx_crc_d = rx_crc_next_s;
          if (cnt_q == LAST_CRC) begin
            cnt_d = CNT_ZERO;
            if (rx_crc_next_s == crc_q) begin
              // c is loaded on entry so it shows the new value while done is high.
              state_d = ST_COMMIT;
              c_d     = shadow_q;
            end else begin
              state_d = ST_ERROR;
              err_d   = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end else begin
          state_d = ST_CRC_RX;
        end
      end

      ST_COMMIT: begin
        state_d = ST_IDLE;
      end

      ST_RB_DATA: begin
        if (out_acc_s) begin
          rb_d  = {1'b0, rb_q[CFG_W-1:1]};
          crc_d = crc8_step(crc_q, rb_q[0]);
          if (cnt_q == LAST_DATA) begin
            state_d = ST_RB_CRC;
            cnt_d   = CNT_ZERO;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end else begin
          state_d = ST_RB_DATA;
        end
      end

      ST_RB_CRC: begin
        if (out_acc_s) begin
          if (cnt_q == LAST_CRC) begin
            state_d = ST_IDLE;
            cnt_d   = CNT_ZERO;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end else begin
          state_d = ST_RB_CRC;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_cfg_loader.sv
// tb_cfg_loader: scoreboard bench for cfg_loader with CFG_W = 8.
module tb_cfg_loader;

  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start, rb_req, in_valid, in_bit, out_ready;
  logic          in_ready, out_valid, out_bit, out_last, busy, done, err;
  logic [CW-1:0] c;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  logic [1:0]    rb_exp_q[$];   // {bit, last}
  logic [CW-1:0] c_exp_q[$];

  logic prev_stall = 1'b0;
  logic prev_bit   = 1'b0;
  logic prev_last  = 1'b0;

  cfg_loader #(.CFG_W(CW), .CNT_W(8), .CRC_POLY(8'h07)) dut (
    .clk(clk), .rst(rst), .start(start), .rb_req(rb_req),
    .in_valid(in_valid), .in_bit(in_bit), .in_ready(in_ready),
    .out_valid(out_valid), .out_bit(out_bit), .out_last(out_last),
    .out_ready(out_ready), .c(c), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference CRC-8 (poly 0x07, init 0) over the bits d[0] first.
  function automatic logic [7:0] crc_model(input logic [CW-1:0] d);
    logic [7:0] r;
    logic fb;
    r = 8'h00;
    for (int i = 0; i < CW; i++) begin
      fb = r[7] ^ d[i];
      r = {r[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    return r;
  endfunction

  // Monitor: scoreboard pops, stall stability, handshake exclusivity.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall <= 1'b0;
    end else begin
      chk("ready_valid_excl", {31'd0, in_ready & out_valid}, 32'd0);
      if (out_valid && prev_stall) begin
        chk("stall_bit", {31'd0, out_bit}, {31'd0, prev_bit});
        chk("stall_last", {31'd0, out_last}, {31'd0, prev_last});
      end
      if (out_valid && out_ready) begin
        if (rb_exp_q.size() == 0) begin
          chk("rb_unexpected", 32'd1, 32'd0);
        end else begin
          logic [1:0] e;
          e = rb_exp_q.pop_front();
          chk("rb_bit", {31'd0, out_bit}, {31'd0, e[1]});
          chk("rb_last", {31'd0, out_last}, {31'd0, e[0]});
        end
      end
      if (done) begin
        done_cnt++;
        if (c_exp_q.size() == 0) begin
          chk("done_unexpected", 32'd1, 32'd0);
        end else begin
          chk("c_on_done", {24'd0, c}, {24'd0, c_exp_q.pop_front()});
        end
      end
      prev_stall <= out_valid && !out_ready;
      prev_bit   <= out_bit;
      prev_last  <= out_last;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_bit(input logic b, input bit gap);
    int n;
    if (gap) begin
      repeat ($urandom_range(0, 2)) begin
        in_valid = 1'b0;
        in_bit   = 1'($urandom_range(0, 1));
        tick();
      end
    end
    in_valid = 1'b1;
    in_bit   = b;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        tick();
        break;
      end
      n++;
      if (n > 50) begin
        chk("in_ready_timeout", 32'd0, 32'd1);
        tick();
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic load_cfg(input logic [CW-1:0] d, input logic [7:0] crc, input bit gap);
    pulse_start();
    for (int i = 0; i < CW; i++) send_bit(d[i], gap);
    for (int i = 7; i >= 0; i--) send_bit(crc[i], gap);
  endtask

  task automatic readback(input logic [CW-1:0] cv, input logic [7:0] cc);
    int n;
    for (int i = 0; i < CW; i++) rb_exp_q.push_back({cv[i], 1'b0});
    for (int i = 7; i >= 0; i--) rb_exp_q.push_back({cc[i], (i == 0) ? 1'b1 : 1'b0});
    rb_req = 1'b1;
    tick();
    rb_req = 1'b0;
    n = 0;
    while (rb_exp_q.size() != 0 && n < 200) begin
      out_ready = ~out_ready;
      tick();
      n++;
    end
    chk("rb_drained", rb_exp_q.size(), 32'd0);
    out_ready = 1'b0;
    rb_exp_q.delete();
    @(negedge clk);
    chk("rb_end_busy", {31'd0, busy}, 32'd0);
    chk("rb_end_valid", {31'd0, out_valid}, 32'd0);
    tick();
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_c"}, {24'd0, c}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
    chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_out_last"}, {31'd0, out_last}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_err"}, {31'd0, err}, 32'd0);
  endtask

  initial begin
    int d0;
    logic [7:0] crc_a5;
    rst = 1'b1; start = 1'b0; rb_req = 1'b0;
    in_valid = 1'b0; in_bit = 1'b0; out_ready = 1'b0;
    repeat (2) tick();
    check_idle_outputs("reset");
    rst = 1'b0;
    tick();

    // Successful load of 0x01 with CRC 0x89.
    d0 = done_cnt;
    c_exp_q.push_back(8'h01);
    load_cfg(8'h01, 8'h89, 1'b0);
    @(negedge clk);
    chk("s1_done", {31'd0, done}, 32'd1);
    chk("s1_c", {24'd0, c}, 32'h01);
    @(negedge clk);
    chk("s1_busy_fall", {31'd0, busy}, 32'd0);
    chk("s1_done_fall", {31'd0, done}, 32'd0);
    chk("s1_err", {31'd0, err}, 32'd0);
    chk("s1_done_once", done_cnt - d0, 32'd1);
    tick();

    // Bad CRC: error flagged, c kept, no done.
    d0 = done_cnt;
    load_cfg(8'h00, 8'h01, 1'b0);
    @(negedge clk);
    chk("s2_err", {31'd0, err}, 32'd1);
    chk("s2_busy", {31'd0, busy}, 32'd0);
    chk("s2_c_held", {24'd0, c}, 32'h01);
    @(negedge clk);
    chk("s2_no_done", done_cnt - d0, 32'd0);
    tick();
    pulse_start();
    @(negedge clk);
    chk("s2_err_cleared", {31'd0, err}, 32'd0);
    chk("s2_in_load", {31'd0, in_ready}, 32'd1);
    tick();

    // Gapped valid load (restarts the open session) of 0x01.
    d0 = done_cnt;
    c_exp_q.push_back(8'h01);
    load_cfg(8'h01, 8'h89, 1'b1);
    repeat (2) @(negedge clk);
    chk("s4_done_once", done_cnt - d0, 32'd1);
    chk("s4_c", {24'd0, c}, 32'h01);
    tick();

    // Readback of 0x01 with out_ready toggling.
    readback(8'h01, 8'h89);

    // Restart after 5 bits, then full load of 0x00 / CRC 0x00.
    d0 = done_cnt;
    pulse_start();
    for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
    c_exp_q.push_back(8'h00);
    load_cfg(8'h00, 8'h00, 1'b0);
    repeat (2) @(negedge clk);
    chk("s5_done_once", done_cnt - d0, 32'd1);
    chk("s5_c", {24'd0, c}, 32'h00);
    tick();

    // Extra pattern: 0xA5 with model CRC, then readback.
    crc_a5 = crc_model(8'hA5);
    c_exp_q.push_back(8'hA5);
    load_cfg(8'hA5, crc_a5, 1'b1);
    repeat (2) @(negedge clk);
    chk("a5_c", {24'd0, c}, 32'hA5);
    tick();
    readback(8'hA5, crc_a5);

    // Reset mid-LOAD.
    pulse_start();
    for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
    #2 rst = 1'b1;
    #1 check_idle_outputs("rst_load");
    tick();
    rst = 1'b0;
    tick();

    // Reload 0x01, then reset mid-RB_DATA.
    c_exp_q.push_back(8'h01);
    load_cfg(8'h01, 8'h89, 1'b0);
    repeat (2) tick();
    rb_req = 1'b1;
    tick();
    rb_req = 1'b0;
    @(negedge clk);
    chk("rb_active", {31'd0, out_valid}, 32'd1);
    chk("rb_c_before_rst", {24'd0, c}, 32'h01);
    #2 rst = 1'b1;
    #1 check_idle_outputs("rst_rb");
    tick();
    rst = 1'b0;
    tick();

    // start and rb_req together: start wins.
    start = 1'b1;
    rb_req = 1'b1;
    tick();
    start = 1'b0;
    rb_req = 1'b0;
    @(negedge clk);
    chk("prio_in_ready", {31'd0, in_ready}, 32'd1);
    chk("prio_out_valid", {31'd0, out_valid}, 32'd0);
    chk("prio_busy", {31'd0, busy}, 32'd1);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule

// File: doc/cfg_loader.md
Name: cfg_loader

Overview:
- Configuration writer/reader for the interconnect fabric.
- Accepts a serial configuration bitstream over a valid/ready handshake and checks it against a trailing CRC-8.
- On a CRC match, commits the bits atomically to the parallel switch-control bus `c`. This bus drives the connection-block transmission gates.
- Also supports readback: serialises the active configuration plus its CRC-8 over a second handshake, so the bitstream can be verified.

Parameters:
- CFG_W, 248: number of configuration bits. Matches the default connection-block `c` width (2×(6×20+1×4)).
- CNT_W, 8: counter width. Must satisfy 2^CNT_W > CFG_W.
- CRC_POLY, 8'h07: CRC-8 polynomial (implicit x^8). Init 8'h00, no reflection, no final XOR.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-high reset
- start  input  1  pulse: begin a load session
- rb_req  input  1  pulse: begin a readback session
- in_valid  input  1  serial write bit valid
- in_bit  input  1  serial write data
- in_ready  output  1  loader accepts a bit this cycle
- out_valid  output  1  readback bit valid
- out_bit  output  1  readback data
- out_last  output  1  marks the final readback bit (CRC bit 0)
- out_ready  input  1  consumer accepts the readback bit
- c  output  CFG_W  active configuration bits
- busy  output  1  state is not IDLE and not ERROR
- done  output  1  one-cycle pulse on successful commit
- err  output  1  sticky CRC-mismatch flag

Behaviour:
- Reset (asynchronous, active-high) forces:
  - state = IDLE
  - c = 0 (all switches open)
  - shadow = 0, crc = 0, cnt = 0
  - in_ready, out_valid, out_last, done, err, busy = 0
- States: IDLE, LOAD, CRC_RX, COMMIT, ERROR, RB_DATA, RB_CRC.
- IDLE / ERROR:
  - start → LOAD; clears cnt, crc and err.
  - Otherwise, rb_req → RB_DATA; copies c into the rb shift register, clears cnt and crc.
  - If start and rb_req are both high, start wins.
- LOAD:
  - in_ready = 1.
  - On each accepted bit (in_valid & in_ready):
    - shadow <= {in_bit, shadow[CFG_W-1:1]}. The first bit received ends at c[0].
    - crc updates bit-serially: fb = crc[7]^in_bit; crc = (crc<<1) ^ (fb ? CRC_POLY : 0).
    - cnt increments.
  - On the accept that brings cnt to CFG_W → CRC_RX with cnt = 0.
- CRC_RX:
  - in_ready = 1.
  - Accepts 8 bits MSB-first into rx_crc.
  - After the 8th accept: → COMMIT if rx_crc == crc, else → ERROR with err = 1.
- COMMIT:
  - Lasts one cycle: c <= shadow, done = 1, then → IDLE.
  - c changes only here.
- start during LOAD or CRC_RX restarts the session: cnt and crc clear, c is untouched. rb_req is ignored while busy.
- RB_DATA:
  - out_valid = 1, out_bit = rb[0].
  - On out_valid & out_ready: rb shifts right, crc updates with out_bit, cnt increments.
  - After CFG_W transfers → RB_CRC.
- RB_CRC:
  - Presents crc MSB-first, 8 bits, holding each until accepted.
  - out_last = 1 on the 8th bit; after it is accepted → IDLE.
- out_bit and out_valid must be stable while out_valid & !out_ready.
- in_ready and out_valid are never high together.
- busy = 1 in LOAD, CRC_RX, COMMIT, RB_DATA and RB_CRC.
- err stays set until the next start or reset. A failed load leaves c unchanged.
- Reset asserted mid-session aborts the session immediately and clears c to 0.

Test Plan:
- CFG_W=8: start, send data bits 1,0,0,0,0,0,0,0 then CRC 8'h89 MSB-first → done pulses once; c = 8'h01; err = 0; busy falls the cycle after done.
- CFG_W=8: load eight zeros with CRC 8'h01 → err = 1; c holds its prior value (8'h01); done never pulses; next start clears err.
- After a successful load of c = 8'h01: rb_req with out_ready toggling every other cycle → out_bit sequence 1,0,0,0,0,0,0,0 then 1,0,0,0,1,0,0,1 (8'h89); out_last only on the final bit; data stable while stalled.
- in_valid gapped randomly during LOAD → only accepted bits count; result identical to the first scenario.
- start re-asserted after 5 bits of a load, then a full valid load of 8'h00 with CRC 8'h00 → c = 8'h00; done pulses once.
- rst asserted mid-LOAD and mid-RB_DATA → c = 0, state IDLE, all outputs 0 asynchronously; start and rb_req in the same IDLE cycle → LOAD entered (in_ready = 1, out_valid = 0).
